// File: rtl/load_lane_ctrl.sv
// Bus-read sequencer feeding the AND-mask filter: word-aligned read, captured data plus byte-lane mask.
// Optional WAIT timeout abort is compiled in with `define LOAD_LANE_TIMEOUT_EN.
module load_lane_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        size,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_rd,
    input  logic              bus_ack,
    input  logic [31:0]       bus_data,
    output logic [31:0]       data_out,
    output logic [31:0]       mask_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [ADDR_W-1:0] bus_addr_reg;
    logic [31:0]       mask_lat_reg;
    logic [31:0]       data_out_reg;
    logic [31:0]       mask_out_reg;
    logic              err_reg;

    logic [3:0]  lane_en;
    logic [31:0] mask_calc;
    logic        illegal;
    logic        accept;
    logic        reject;
    logic        timeout_hit;

    // Each byte lane decides independently whether the access covers it.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign lane_en[gi] = (size == 2'd0) ? (addr[1:0] == LANE) :
                                 (size == 2'd1) ? (addr[1] == LANE[1]) :
                                                  1'b1;
            assign mask_calc[8*gi +: 8] = {8{lane_en[gi]}};
        end
    endgenerate

    assign illegal = (size == 2'd3)
                   || ((size == 2'd1) && addr[0])
                   || ((size == 2'd2) && (addr[1:0] != 2'b00));
    assign accept  = (state_reg == S_IDLE) && start && !illegal;
    assign reject  = (state_reg == S_IDLE) && start && illegal;

`ifdef LOAD_LANE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_reg;

    // Abort on the last allowed WAIT cycle only if ack is absent; a coincident ack completes normally.
    assign timeout_hit = (state_reg == S_WAIT) && !bus_ack
                       && (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_reg <= '0;
        end else if (state_reg == S_REQ) begin
            wait_cnt_reg <= '0;
        end else if ((state_reg == S_WAIT) && !bus_ack) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    // TIMEOUT_CYCLES has no effect when the timeout is not built in.
    generate
        if (TIMEOUT_CYCLES < 1) begin : g_no_timeout
        end
    endgenerate
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_IDLE: if (accept) state_next = S_REQ;
            S_REQ:  state_next = S_WAIT;
            S_WAIT: begin
                if (bus_ack) begin
                    state_next = S_DONE;
                end else if (timeout_hit) begin
                    state_next = S_IDLE;
                end
            end
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_addr_reg <= '0;
            mask_lat_reg <= '0;
            data_out_reg <= '0;
            mask_out_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            err_reg <= reject || timeout_hit;
            if (accept) begin
                bus_addr_reg <= {addr[ADDR_W-1:2], 2'b00};
                mask_lat_reg <= mask_calc;
            end
            // Outputs only change on a completed read, so rejects and aborts leave them intact.
            if ((state_reg == S_WAIT) && bus_ack) begin
                data_out_reg <= bus_data;
                mask_out_reg <= mask_lat_reg;
            end
        end
    end

    assign busy     = (state_reg != S_IDLE);
    assign done     = (state_reg == S_DONE);
    assign bus_rd   = (state_reg == S_REQ) || (state_reg == S_WAIT);
    assign err      = err_reg;
    assign bus_addr = bus_addr_reg;
    assign data_out = data_out_reg;
    assign mask_out = mask_out_reg;

endmodule
